// File: rtl/hist_pkg.sv
// Shared types for the ping-pong histogram: read-bank state encoding and
// the bin-index width helper used by every file in this slice.
package hist_pkg;

  typedef enum logic [1:0] {
    RDB_EMPTY    = 2'd0,
    RDB_FULL     = 2'd1,
    RDB_CLEARING = 2'd2
  } rdb_state_t;

  function automatic int bin_w(input int num_bins);
    return (num_bins <= 2) ? 1 : $clog2(num_bins);
  endfunction

endpackage

// File: rtl/hist_pingpong_if.sv
// Pixel stream and histogram read port of hist_pingpong.
// Handshake: a pixel transfers on a rising edge where pix_valid and pix_ready
// are both high; pix_last is qualified by pix_valid. rd_en and rd_release are
// single-cycle requests with no ready; rd_data is valid only while rd_valid=1.
interface hist_pingpong_if #(
  parameter int PIX_W    = 8,
  parameter int NUM_BINS = 16,
  parameter int CNT_W    = 16
);
  localparam int BIN_W = hist_pkg::bin_w(NUM_BINS);

  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;
  logic             pix_ready;
  logic             hist_ready;
  logic             rd_en;
  logic [BIN_W-1:0] rd_addr;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_release;
  logic             rd_sat;
  logic [31:0]      rd_pixels;

  modport master (
    output pix_valid, pix_data, pix_last, rd_en, rd_addr, rd_release,
    input  pix_ready, hist_ready, rd_valid, rd_data, rd_sat, rd_pixels
  );

  modport slave (
    input  pix_valid, pix_data, pix_last, rd_en, rd_addr, rd_release,
    output pix_ready, hist_ready, rd_valid, rd_data, rd_sat, rd_pixels
  );

endinterface

// File: rtl/hist_bank.sv
// One bank of NUM_BINS saturating bin counters with an increment port,
// a one-bin-per-cycle clear port and a registered read port.
module hist_bank
  import hist_pkg::*;
#(
  parameter int NUM_BINS = 16,
  parameter int CNT_W    = 16,
  parameter int BIN_W    = bin_w(NUM_BINS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [BIN_W-1:0] inc_bin,
  output logic             inc_sat,
  input  logic             clr_en,
  input  logic [BIN_W-1:0] clr_bin,
  input  logic             rd_en,
  input  logic [BIN_W-1:0] rd_addr,
  output logic [CNT_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NUM_BINS];
  logic             at_max;

  assign at_max  = (cnt[inc_bin] == CNT_MAX);
  // Flags an increment that was blocked because the bin is already full.
  assign inc_sat = inc_en && at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        cnt[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (clr_en) begin
        cnt[clr_bin] <= '0;
      end else if (inc_en && !at_max) begin
        cnt[inc_bin] <= cnt[inc_bin] + 1'b1;
      end
      if (rd_en) begin
        rd_data <= cnt[rd_addr];
      end
    end
  end

endmodule

// File: rtl/hist_pingpong.sv
// Ping-pong histogram: one bank accumulates the incoming frame while the other
// holds the previous frame for readout, then is swept clear and swapped in.
module hist_pingpong
  import hist_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int NUM_BINS = 16,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  hist_pingpong_if.slave  bus,
  output rdb_state_t      dbg_state
);

  localparam int BIN_W = bin_w(NUM_BINS);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  rdb_state_t       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             pend_q, pend_d;
  logic [BIN_W-1:0] clr_idx_q, clr_idx_d;

  logic             acc_sat_q, rd_sat_q;
  logic [31:0]      acc_pix_q, rd_pix_q;
  logic             rd_valid_q, rd_bank_q;

  logic             accept, frame_end, clear_done, swap_req, do_swap, rd_fire;
  logic [BIN_W-1:0] pix_bin;
  logic             inc_sat0, inc_sat1, acc_inc_sat;
  logic [CNT_W-1:0] rdata0, rdata1;
  logic             acc_sat_nx;
  logic [31:0]      acc_pix_nx;
  logic             unused_pix;

  assign accept     = bus.pix_valid && bus.pix_ready;
  assign pix_bin    = bus.pix_data[PIX_W-1 -: BIN_W];
  assign unused_pix = ^bus.pix_data;
  assign frame_end  = accept && bus.pix_last;
  assign clear_done = (state_q == RDB_CLEARING) && (clr_idx_q == LAST_BIN);
  // A swap waits for the read bank to be empty, including the edge that empties it.
  assign swap_req   = pend_q || frame_end;
  assign do_swap    = swap_req && ((state_q == RDB_EMPTY) || clear_done);
  assign rd_fire    = bus.rd_en && (state_q == RDB_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RDB_EMPTY;
      ptr_q     <= 1'b0;
      pend_q    <= 1'b0;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pend_q    <= pend_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_idx_d = clr_idx_q;
    pend_d    = swap_req && !do_swap;
    case (state_q)
      RDB_FULL: begin
        if (bus.rd_release) begin
          state_d   = RDB_CLEARING;
          clr_idx_d = '0;
        end
      end
      RDB_CLEARING: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clear_done) begin
          state_d = RDB_EMPTY;
        end
      end
      default: ;
    endcase
    if (do_swap) begin
      state_d = RDB_FULL;
      ptr_d   = ~ptr_q;
    end
  end

  // ptr_q names the accumulate bank; the other bank is the read bank.
  assign acc_inc_sat = ptr_q ? inc_sat1 : inc_sat0;
  assign acc_sat_nx  = acc_sat_q | acc_inc_sat;
  assign acc_pix_nx  = acc_pix_q + 32'(accept);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_sat_q  <= 1'b0;
      acc_pix_q  <= '0;
      rd_sat_q   <= 1'b0;
      rd_pix_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      if (do_swap) begin
        rd_sat_q  <= acc_sat_nx;
        rd_pix_q  <= acc_pix_nx;
        acc_sat_q <= 1'b0;
        acc_pix_q <= '0;
      end else begin
        acc_sat_q <= acc_sat_nx;
        acc_pix_q <= acc_pix_nx;
      end
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_bank_q <= ~ptr_q;
      end
    end
  end

  hist_bank #(.NUM_BINS(NUM_BINS), .CNT_W(CNT_W), .BIN_W(BIN_W)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (accept && !ptr_q),
    .inc_bin (pix_bin),
    .inc_sat (inc_sat0),
    .clr_en  ((state_q == RDB_CLEARING) && ptr_q),
    .clr_bin (clr_idx_q),
    .rd_en   (rd_fire && ptr_q),
    .rd_addr (bus.rd_addr),
    .rd_data (rdata0)
  );

  hist_bank #(.NUM_BINS(NUM_BINS), .CNT_W(CNT_W), .BIN_W(BIN_W)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (accept && ptr_q),
    .inc_bin (pix_bin),
    .inc_sat (inc_sat1),
    .clr_en  ((state_q == RDB_CLEARING) && !ptr_q),
    .clr_bin (clr_idx_q),
    .rd_en   (rd_fire && !ptr_q),
    .rd_addr (bus.rd_addr),
    .rd_data (rdata1)
  );

  assign bus.pix_ready  = !pend_q;
  assign bus.hist_ready = (state_q == RDB_FULL);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_valid_q ? (rd_bank_q ? rdata1 : rdata0) : '0;
  assign bus.rd_sat     = rd_sat_q;
  assign bus.rd_pixels  = rd_pix_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/hist_pingpong.md
HIST_PINGPONG -- requirements
Module: hist_pingpong

Interface
REQ-001 SHALL have parameter PIX_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter NUM_BINS, default 16: bin count, a power of two, 2 <= NUM_BINS <= 2**PIX_W.
REQ-003 SHALL have parameter CNT_W, default 16: bin counter width in bits.
REQ-004 SHALL have port clk, input, 1: clock, all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port pix_valid, input, 1: pixel present.
REQ-007 SHALL have port pix_data, input, PIX_W: pixel value.
REQ-008 SHALL have port pix_last, input, 1: last pixel of the frame; qualified by pix_valid.
REQ-009 SHALL have port pix_ready, output, 1: pixel accepted when pix_valid and pix_ready are both high.
REQ-010 SHALL have port hist_ready, output, 1: a completed histogram is readable.
REQ-011 SHALL have port rd_en, input, 1: read request.
REQ-012 SHALL have port rd_addr, input, log2(NUM_BINS): bin index to read.
REQ-013 SHALL have port rd_valid, output, 1: rd_data valid.
REQ-014 SHALL have port rd_data, output, CNT_W: bin count.
REQ-015 SHALL have port rd_release, input, 1: pulse that frees the read bank.
REQ-016 SHALL have port rd_sat, output, 1: the read bank saturated at least one bin.
REQ-017 SHALL have port rd_pixels, output, 32: number of pixels accepted into the read bank.

Function
REQ-018 SHALL hold two banks of NUM_BINS counters, each CNT_W bits: an accumulate bank (acc) and a read bank (rdb), selected by a 1-bit pointer.
REQ-019 SHALL compute bin = pix_data >> (PIX_W - log2(NUM_BINS)) and add 1 to acc[bin] on the clock edge of each accepted pixel; there is no read-modify-write hazard for back-to-back pixels.
REQ-020 SHALL saturate each counter at 2**CNT_W-1; a saturating increment sets the acc bank's sticky sat flag.
REQ-021 SHALL increment an acc pixel counter per accepted pixel; this counter wraps at 2**32.
REQ-022 SHALL track rdb state: EMPTY, FULL or CLEARING.
REQ-023 SHALL swap banks on the same edge when the pixel carrying pix_last is accepted and rdb is EMPTY.
- the final pixel is counted into the bank that becomes rdb;
- rdb becomes FULL;
- the new acc bank starts at zero, with sat=0 and pixels=0.
REQ-024 SHALL latch a pending swap when pix_last is accepted and rdb is not EMPTY.
- pix_ready is 0 while the swap is pending;
- the swap occurs on the edge on which rdb reaches EMPTY;
- pix_ready returns to 1 on the next cycle.
REQ-025 SHALL drive pix_ready=1 at all other times; the block has no other backpressure source.
REQ-026 SHALL drive hist_ready=1 exactly when rdb is FULL; rd_sat and rd_pixels SHALL reflect rdb and are meaningful only while hist_ready=1.
REQ-027 SHALL respond to rd_en in FULL with rd_data=rdb[rd_addr] and rd_valid=1 one cycle later, at a throughput of one read per cycle.
REQ-028 SHALL ignore rd_en outside FULL (rd_valid=0), and SHALL drive rd_data=0 whenever rd_valid=0.
REQ-029 SHALL move rdb from FULL to CLEARING on rd_release.
- CLEARING zeroes one bin per cycle, index 0 to NUM_BINS-1, then goes to EMPTY;
- total CLEARING time is exactly NUM_BINS cycles;
- rd_release outside FULL is ignored.
REQ-030 SHALL, when rd_en and rd_release occur in the same cycle, return the read data normally on the next cycle, with clearing starting after the read.
REQ-031 SHALL treat a pixel that has pix_last and also causes saturation as both counted and flagged before the swap.

Reset
REQ-032 SHALL, on reset, on the next edge:
- zero all counters in both banks;
- set pointer=0, rdb=EMPTY, no pending swap;
- clear sat flags and pixel counters;
- drive pix_ready=1, hist_ready=0, rd_valid=0, rd_data=0, rd_sat=0, rd_pixels=0.
REQ-033 SHALL let reset override any in-progress swap, clear sweep or read; a read that was outstanding SHALL produce no rd_valid.

Structure
REQ-034 SHALL place the rdb state encoding (EMPTY, FULL, CLEARING) and the bin-index width function in the shared package hist_pkg.
REQ-035 SHALL instantiate one sub-module, hist_bank, twice: NUM_BINS saturating counters with increment, sweep-clear and registered read ports.

Verification
REQ-036 SHALL, with NUM_BINS=8 and PIX_W=8, send pixels 0,31,32,255,255 with pix_last on the last pixel, then read bins 0..7 -> counts 2,1,0,0,0,0,0,2; rd_pixels=5; rd_sat=0; hist_ready=1 on the cycle after the last pixel.
REQ-037 SHALL, with CNT_W=4, send 20 pixels of value 10 plus pix_last -> bin 0 reads 15 and rd_sat=1.
REQ-038 SHALL, after frame 1 is complete and not released, stream frame 2 of 3 pixels with pix_last -> pix_ready=0 from the cycle after that last pixel; rd_release -> after 8 clear cycles, swap occurs, hist_ready=1 with frame-2 data, pix_ready=1.
REQ-039 SHALL issue rd_en and rd_release together on bin 3 holding 7 -> rd_valid=1 with rd_data=7 next cycle; hist_ready=0; a re-read after the sweep returns rd_valid=0.
REQ-040 SHALL assert reset mid-CLEARING with frame pixels in acc -> next cycle all outputs are at reset values; a fresh 1-pixel frame of value 200 reads bin 6 = 1 and all other bins 0.
